alu_mdu: RTL and testbench

//  Parametrised execute-stage ALU with an iterative multiply/divide unit (MDU) and HI/LO registers.

---
 rtl/alu_mdu_pkg.sv | 51 +++++
 rtl/alu_mdu_if.sv | 33 +++
 rtl/alu_mdu_mdu_seq.sv | 159 +++++++++++++++
 rtl/alu_mdu.sv | 89 ++++++++
 tb/tb_alu_mdu.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_pkg.sv
// -----------------------------------------------------------------------------
// alu_mdu_pkg
// Shared definitions for the execute-stage ALU and its multiply/divide unit.
// These definitions are shared with the control unit:
//   - 5-bit ALUCTR_* operation codes
//   - MDU sequencer state encoding
//   - small helpers that classify an operation code
// -----------------------------------------------------------------------------
package alu_mdu_pkg;

    // Simple, single-cycle operations
    localparam logic [4:0] ALUCTR_AND   = 5'd0;
    localparam logic [4:0] ALUCTR_OR    = 5'd1;
    localparam logic [4:0] ALUCTR_XOR   = 5'd2;
    localparam logic [4:0] ALUCTR_NOR   = 5'd3;
    localparam logic [4:0] ALUCTR_ADD   = 5'd4;
    localparam logic [4:0] ALUCTR_ADDU  = 5'd5;
    localparam logic [4:0] ALUCTR_SUB   = 5'd6;
    localparam logic [4:0] ALUCTR_SUBU  = 5'd7;
    localparam logic [4:0] ALUCTR_SLT   = 5'd8;
    localparam logic [4:0] ALUCTR_SLTU  = 5'd9;
    localparam logic [4:0] ALUCTR_SLL   = 5'd10;
    localparam logic [4:0] ALUCTR_SRL   = 5'd11;
    localparam logic [4:0] ALUCTR_SRA   = 5'd12;
    localparam logic [4:0] ALUCTR_LUI   = 5'd13;

    // Multi-cycle multiply/divide and HI/LO moves
    localparam logic [4:0] ALUCTR_MULT  = 5'd16;
    localparam logic [4:0] ALUCTR_MULTU = 5'd17;
    localparam logic [4:0] ALUCTR_DIV   = 5'd18;
    localparam logic [4:0] ALUCTR_DIVU  = 5'd19;
    localparam logic [4:0] ALUCTR_MTHI  = 5'd20;
    localparam logic [4:0] ALUCTR_MTLO  = 5'd21;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    // True for the codes that occupy the iterative engine
    function automatic logic is_mdu_op(input logic [4:0] op);
        return op inside {ALUCTR_MULT, ALUCTR_MULTU, ALUCTR_DIV, ALUCTR_DIVU};
    endfunction

    // True for the MDU codes that treat operands as two's complement
    function automatic logic is_signed_mdu(input logic [4:0] op);
        return (op == ALUCTR_MULT) || (op == ALUCTR_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// -----------------------------------------------------------------------------
// alu_mdu_if
// Bundle between the datapath/control and the ALU+MDU.
//   A, B, shamt, ALUctr, start : datapath -> ALU (master drives)
//   res, busy, done, hi, lo, ovf : ALU -> datapath (slave drives)
// Modports: master (datapath side), slave (ALU side).
// -----------------------------------------------------------------------------
interface alu_mdu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic [4:0]       ALUctr;
    logic             start;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;

    modport master (
        output A, B, shamt, ALUctr, start,
        input  res, busy, done, hi, lo, ovf
    );

    modport slave (
        input  A, B, shamt, ALUctr, start,
        output res, busy, done, hi, lo, ovf
    );
endinterface

// File: rtl/alu_mdu_mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
// Iterative multiply/divide engine with the HI/LO registers.
// Operates on operand magnitudes, one radix-2 step per cycle, then applies the
// sign correction in a single FIX cycle and writes HI/LO at the end of it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       launch pulse and operation code (MDU ops, MTHI, MTLO)
//   a, b            operands, sampled at launch
//   busy            high in RUN and FIX
//   done            one-cycle pulse, first IDLE cycle after FIX
//   hi, lo          HI/LO registers
// -----------------------------------------------------------------------------
module mdu_seq
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state, next_state;
    logic [SHW-1:0]     count;
    logic               op_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   quo;

    logic               launch;
    logic               in_sa, in_sb;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_acc, step_quo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign launch = (state == MDU_IDLE) && start && is_mdu_op(op);
    assign in_sa  = is_signed_mdu(op) && a[WIDTH-1];
    assign in_sb  = is_signed_mdu(op) && b[WIDTH-1];
    assign busy   = (state != MDU_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: launch from IDLE, WIDTH steps in RUN, one FIX cycle
    always_comb begin
        next_state = state;
        case (state)
            MDU_IDLE: if (launch) next_state = MDU_RUN;
            MDU_RUN:  if (count == '0) next_state = MDU_FIX;
            MDU_FIX:  next_state = MDU_IDLE;
            default:  next_state = MDU_IDLE;
        endcase
    end

    // One iteration step.
    // Multiply: {acc,quo} is the partial product with the multiplier in quo;
    // add the multiplicand when the low bit is set, then shift right.
    // Divide: restoring division, dividend shifts out of quo into acc and the
    // quotient bits shift in behind it.
    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        step_acc  = mul_sum[WIDTH:1];
        step_quo  = {mul_sum[0], quo[WIDTH-1:1]};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_quo = {quo[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_quo = {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction. Division by zero bypasses the engine result: the
    // original A is rebuilt from its magnitude and sign and lands in HI.
    always_comb begin
        prod     = {acc, quo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (mag_b == '0) begin
                fix_lo = '1;
                fix_hi = sign_a ? -mag_a : mag_a;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? -quo : quo;
                fix_hi = sign_a ? -acc : acc;
            end
        end
    end

    // Datapath registers, HI/LO and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            op_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            quo    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == MDU_FIX);
            case (state)
                MDU_IDLE: begin
                    if (launch) begin
                        count  <= SHW'(WIDTH - 1);
                        op_div <= (op == ALUCTR_DIV) || (op == ALUCTR_DIVU);
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        mag_a  <= in_sa ? -a : a;
                        mag_b  <= in_sb ? -b : b;
                        acc    <= '0;
                        quo    <= in_sa ? -a : a;
                    end else if (start && (op == ALUCTR_MTHI)) begin
                        hi <= a;
                    end else if (start && (op == ALUCTR_MTLO)) begin
                        lo <= a;
                    end
                end
                MDU_RUN: begin
                    acc   <= step_acc;
                    quo   <= step_quo;
                    count <= count - 1'b1;
                end
                MDU_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// Execute-stage ALU: combinational simple ops on res, plus the iterative
// multiply/divide unit (mdu_seq) that owns HI/LO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  A, B, shamt, ALUctr, start in; res, busy, done, hi, lo, ovf out
// Configuration:
//   ALU_OVF_EN   when defined, ovf flags signed overflow of ADD and SUB;
//                otherwise ovf is tied low.
// -----------------------------------------------------------------------------
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);

    logic [WIDTH-1:0] a, b, res, sum, diff;
    logic [SHW-1:0]   shamt;
    logic [4:0]       ctr;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    assign a     = bus.A;
    assign b     = bus.B;
    assign shamt = bus.shamt;
    assign ctr   = bus.ALUctr;
    assign sum   = a + b;
    assign diff  = a - b;

    // Simple ops; MDU, move and undefined codes all read as zero
    always_comb begin
        res = '0;
        case (ctr)
            ALUCTR_AND:  res = a & b;
            ALUCTR_OR:   res = a | b;
            ALUCTR_XOR:  res = a ^ b;
            ALUCTR_NOR:  res = ~(a | b);
            ALUCTR_ADD,
            ALUCTR_ADDU: res = sum;
            ALUCTR_SUB,
            ALUCTR_SUBU: res = diff;
            ALUCTR_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUCTR_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALUCTR_SLL:  res = b << shamt;
            ALUCTR_SRL:  res = b >> shamt;
            ALUCTR_SRA:  res = $signed(b) >>> shamt;
            ALUCTR_LUI:  res = b << (WIDTH / 2);
            default:     res = '0;
        endcase
    end

    assign bus.res = res;

`ifdef ALU_OVF_EN
    // Overflow when like-signed operands give an unlike-signed result
    assign bus.ovf = ((ctr == ALUCTR_ADD) && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                  || ((ctr == ALUCTR_SUB) && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]));
`else
    assign bus.ovf = 1'b0;
`endif

    mdu_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mdu_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.start),
        .op    (ctr),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Self-checking bench for alu_mdu. Expected values come from a behavioural
// model using plain 64-bit arithmetic. Inputs change on the falling edge and
// outputs are sampled on the falling edge (or #1 after it for combinational res).
// -----------------------------------------------------------------------------
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int W = 32;
    localparam int S = 5;
`ifdef ALU_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W), .SHW(S)) bus ();

    alu_mdu #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    // Reference for the combinational ALU
    function automatic void alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] sh, output logic [31:0] r, output logic o);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        o  = 1'b0;
        case (op)
            ALUCTR_AND:  r = a & b;
            ALUCTR_OR:   r = a | b;
            ALUCTR_XOR:  r = a ^ b;
            ALUCTR_NOR:  r = ~(a | b);
            ALUCTR_ADD:  begin t = sa + sb; r = t[31:0]; o = OVF_EN && (t != longint'($signed(t[31:0]))); end
            ALUCTR_ADDU: r = a + b;
            ALUCTR_SUB:  begin t = sa - sb; r = t[31:0]; o = OVF_EN && (t != longint'($signed(t[31:0]))); end
            ALUCTR_SUBU: r = a - b;
            ALUCTR_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALUCTR_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALUCTR_SLL:  r = b << sh;
            ALUCTR_SRL:  r = b >> sh;
            ALUCTR_SRA:  begin t = sb >>> sh; r = t[31:0]; end
            ALUCTR_LUI:  r = b << 16;
            default:     r = '0;
        endcase
    endfunction

    // Reference for the MDU: full-width products and truncating division
    function automatic void mdu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        longint      sp, sq, sr;
        logic [63:0] up;
        h = '0;
        l = '0;
        case (op)
            ALUCTR_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                h = up[63:32]; l = up[31:0];
            end
            ALUCTR_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32]; l = up[31:0];
            end
            ALUCTR_DIV: begin
                if (b == 32'd0) begin
                    l = '1; h = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    l = sq[31:0]; h = sr[31:0];
                end
            end
            ALUCTR_DIVU: begin
                if (b == 32'd0) begin
                    l = '1; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got %h expected 0", bus.lo); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_simple_directed;
        vec_t v[$];
        v.push_back('{ALUCTR_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, OVF_EN});
        v.push_back('{ALUCTR_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0});
        v.push_back('{ALUCTR_SUB,  32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, OVF_EN});
        v.push_back('{ALUCTR_SUBU, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0});
        v.push_back('{ALUCTR_SRA,  32'h00000000, 32'hF0000000, 5'd4, 32'hFF000000, 1'b0});
        v.push_back('{ALUCTR_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0});
        v.push_back('{ALUCTR_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0});
        v.push_back('{ALUCTR_LUI,  32'h00000000, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0});
        v.push_back('{5'd30,       32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, 1'b0});
        v.push_back('{ALUCTR_MULT, 32'h00000005, 32'h00000007, 5'd0, 32'h00000000, 1'b0});
        foreach (v[i]) begin
            @(negedge clk);
            bus.ALUctr = v[i].op; bus.A = v[i].a; bus.B = v[i].b; bus.shamt = v[i].sh;
            #1;
            checks++; if (bus.res !== v[i].res) begin errors++; $display("[TB] FAIL simple_dir[%0d] res got %h expected %h", i, bus.res, v[i].res); end
            checks++; if (bus.ovf !== v[i].ovf) begin errors++; $display("[TB] FAIL simple_dir[%0d] ovf got %b expected %b", i, bus.ovf, v[i].ovf); end
        end
    endtask

    task automatic test_simple_random;
        logic [31:0] r, h0, l0;
        logic        o;
        h0 = bus.hi;
        l0 = bus.lo;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.ALUctr = 5'($urandom_range(0, 31));
            bus.A = $urandom; bus.B = $urandom; bus.shamt = 5'($urandom);
            if (i % 5 == 0) bus.A = {bus.B[31], 31'($urandom)};
            alu_model(bus.ALUctr, bus.A, bus.B, bus.shamt, r, o);
            #1;
            checks++; if (bus.res !== r) begin errors++; $display("[TB] FAIL simple_rnd op=%0d res got %h expected %h", bus.ALUctr, bus.res, r); end
            checks++; if (bus.ovf !== o) begin errors++; $display("[TB] FAIL simple_rnd op=%0d ovf got %b expected %b", bus.ALUctr, bus.ovf, o); end
        end
        @(negedge clk);
        checks++; if (bus.hi !== h0 || bus.lo !== l0) begin errors++; $display("[TB] FAIL simple_keeps_hilo got %h/%h expected %h/%h", bus.hi, bus.lo, h0, l0); end
    endtask

    // Launch one MDU op, wait for done within a bound, check latency and HI/LO
    task automatic run_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int cyc, bc;
        mdu_model(op, a, b, eh, el);
        @(negedge clk);
        bus.ALUctr = op; bus.A = a; bus.B = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.ALUctr = ALUCTR_XOR; bus.A = $urandom; bus.B = $urandom;
        cyc = 0; bc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != W + 1) begin errors++; $display("[TB] FAIL mdu_latency op=%0d got %0d expected %0d", op, cyc, W + 1); end
        checks++; if (bc != W + 1) begin errors++; $display("[TB] FAIL mdu_busy_cycles op=%0d got %0d expected %0d", op, bc, W + 1); end
        checks++; if (bus.hi !== eh) begin errors++; $display("[TB] FAIL mdu_hi op=%0d a=%h b=%h got %h expected %h", op, a, b, bus.hi, eh); end
        checks++; if (bus.lo !== el) begin errors++; $display("[TB] FAIL mdu_lo op=%0d a=%h b=%h got %h expected %h", op, a, b, bus.lo, el); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mdu_busy_at_done got %b expected 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mdu_done_pulse got %b expected 0", bus.done); end
    endtask

    task automatic test_mdu_directed;
        run_mdu(ALUCTR_MULT,  32'hFFFFFFFE, 32'h00000003);
        run_mdu(ALUCTR_MULTU, 32'hFFFFFFFE, 32'h00000003);
        run_mdu(ALUCTR_MULT,  32'h80000000, 32'h80000000);
        run_mdu(ALUCTR_DIV,   32'hFFFFFFF9, 32'h00000002);
        run_mdu(ALUCTR_DIVU,  32'h00000007, 32'h00000000);
        run_mdu(ALUCTR_DIV,   32'hFFFFFFF9, 32'h00000000);
        run_mdu(ALUCTR_DIV,   32'h80000000, 32'hFFFFFFFF);
        run_mdu(ALUCTR_DIVU,  32'hFFFFFFFF, 32'h00000010);
    endtask

    task automatic test_mdu_random;
        logic [4:0]  ops[4];
        logic [31:0] b;
        ops = '{ALUCTR_MULT, ALUCTR_MULTU, ALUCTR_DIV, ALUCTR_DIVU};
        for (int i = 0; i < 16; i++) begin
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 255));
            run_mdu(ops[$urandom_range(0, 3)], $urandom, b);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        @(negedge clk);
        bus.ALUctr = ALUCTR_MTHI; bus.A = x; bus.start = 1'b1;
        @(negedge clk);
        bus.ALUctr = ALUCTR_MTLO; bus.A = y;
        checks++; if (bus.hi !== x) begin errors++; $display("[TB] FAIL mthi got %h expected %h", bus.hi, x); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy got %b expected 0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.lo !== y) begin errors++; $display("[TB] FAIL mtlo got %h expected %h", bus.lo, y); end
        checks++; if (bus.hi !== x) begin errors++; $display("[TB] FAIL mtlo_keeps_hi got %h expected %h", bus.hi, x); end
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_flags got %b%b expected 00", bus.done, bus.busy); end
    endtask

    // Starts issued mid-operation (MULTU and MTHI) must not change the result
    task automatic test_busy_ignore;
        logic [31:0] eh, el;
        int cyc;
        mdu_model(ALUCTR_DIV, 32'h80000000, 32'hFFFFFFFF, eh, el);
        @(negedge clk);
        bus.ALUctr = ALUCTR_DIV; bus.A = 32'h80000000; bus.B = 32'hFFFFFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.start  = (cyc == 5) || (cyc == 8);
            bus.ALUctr = (cyc == 8) ? ALUCTR_MTHI : ALUCTR_MULTU;
            bus.A = 32'hDEADBEEF; bus.B = 32'h00000005;
        end
        bus.start = 1'b0;
        checks++; if (cyc != W + 1) begin errors++; $display("[TB] FAIL ignore_latency got %0d expected %0d", cyc, W + 1); end
        checks++; if (bus.hi !== eh) begin errors++; $display("[TB] FAIL ignore_hi got %h expected %h", bus.hi, eh); end
        checks++; if (bus.lo !== el) begin errors++; $display("[TB] FAIL ignore_lo got %h expected %h", bus.lo, el); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_queue busy got %b expected 0", bus.busy); end
    endtask

    // A start in the done cycle launches the next op immediately
    task automatic test_back_to_back;
        logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
        int cyc;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        mdu_model(ALUCTR_MULTU, a1, b1, h1, l1);
        mdu_model(ALUCTR_DIV, a2, b2, h2, l2);
        @(negedge clk);
        bus.ALUctr = ALUCTR_MULTU; bus.A = a1; bus.B = b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (bus.hi !== h1 || bus.lo !== l1) begin errors++; $display("[TB] FAIL b2b_first got %h/%h expected %h/%h", bus.hi, bus.lo, h1, l1); end
        bus.ALUctr = ALUCTR_DIV; bus.A = a2; bus.B = b2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_launch busy/done got %b%b expected 10", bus.busy, bus.done); end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (cyc != W + 1) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", cyc, W + 1); end
        checks++; if (bus.hi !== h2 || bus.lo !== l2) begin errors++; $display("[TB] FAIL b2b_second got %h/%h expected %h/%h", bus.hi, bus.lo, h2, l2); end
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a multiply
    task automatic test_reset_mid;
        @(negedge clk);
        bus.ALUctr = ALUCTR_MTHI; bus.A = 32'h12345678; bus.start = 1'b1;
        @(negedge clk);
        bus.ALUctr = ALUCTR_MTLO; bus.A = 32'h9ABCDEF0;
        @(negedge clk);
        bus.ALUctr = ALUCTR_MULT; bus.A = 32'hFFFFFFFE; bus.B = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_pre_busy got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_flags got %b%b expected 00", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid_hilo got %h/%h expected 0/0", bus.hi, bus.lo); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_mdu(ALUCTR_MULT, 32'hFFFFFFFE, 32'h00000003);
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.shamt = '0; bus.ALUctr = '0; bus.start = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_simple_directed();
        test_simple_random();
        test_mthi_mtlo();
        test_mdu_directed();
        test_mdu_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
